// File: rtl/fpga_cfg_loader.sv
// Configuration loader for the 2x2 fpga_top. It accepts host words over valid/ready,
// serialises them LSB-first and loads the connection chain, then the CLB chain. It also
// generates the scan clock as registered half-rate pulses and raises a sticky done flag.
module fpga_cfg_loader #(
  parameter int unsigned CONN_CHAIN_LEN = 256,
  parameter int unsigned CLB_CHAIN_LEN  = 64,
  parameter int unsigned WORD_WIDTH     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_start_i,
  input  logic [WORD_WIDTH-1:0] cfg_data_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  output logic                  scan_clk_o,
  output logic                  conn_scan_in_o,
  output logic                  conn_scan_en_o,
  output logic                  clb_scan_in_o,
  output logic                  clb_scan_en_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned MaxLen = (CONN_CHAIN_LEN > CLB_CHAIN_LEN) ? CONN_CHAIN_LEN
                                                                    : CLB_CHAIN_LEN;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);
  localparam int unsigned IdxW   = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  localparam logic [CntW-1:0] ConnLast = CntW'(CONN_CHAIN_LEN - 1);
  localparam logic [CntW-1:0] ClbLast  = CntW'(CLB_CHAIN_LEN - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(WORD_WIDTH - 1);

  // DONE is StIdle with done_q set.
  typedef enum logic [1:0] {StIdle, StConn, StClb, StFlush} state_e;

  state_e                state_q;
  logic [WORD_WIDTH-1:0] buf_q;
  logic [IdxW-1:0]       idx_q;
  logic                  full_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic                  scan_clk_q;
  logic                  conn_in_q;
  logic                  conn_en_q;
  logic                  clb_in_q;
  logic                  clb_en_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  shifting;
  logic                  last_bit;
  logic [IdxW-1:0]       idx_nxt;

  // Decode of the current bit position relative to the active chain.
  always_comb begin
    shifting = (state_q == StConn) || (state_q == StClb);
    last_bit = (state_q == StConn) ? (bit_cnt_q == ConnLast) : (bit_cnt_q == ClbLast);
    idx_nxt  = idx_q + 1'b1;
  end

  assign cfg_ready_o    = shifting && !full_q;
  assign scan_clk_o     = scan_clk_q;
  assign conn_scan_in_o = conn_in_q;
  assign conn_scan_en_o = conn_en_q;
  assign clb_scan_in_o  = clb_in_q;
  assign clb_scan_en_o  = clb_en_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

  // Load FSM: word buffer, bit counter and all registered scan outputs.
  // While the buffer is full, scan_clk_q doubles as the phase flag: 0 = phase A, 1 = phase B.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      buf_q      <= '0;
      idx_q      <= '0;
      full_q     <= 1'b0;
      bit_cnt_q  <= '0;
      scan_clk_q <= 1'b0;
      conn_in_q  <= 1'b0;
      conn_en_q  <= 1'b0;
      clb_in_q   <= 1'b0;
      clb_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfg_start_i) begin
            state_q   <= StConn;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            conn_en_q <= 1'b1;
            conn_in_q <= 1'b0;
            bit_cnt_q <= '0;
            full_q    <= 1'b0;
            idx_q     <= '0;
          end
        end
        StConn, StClb: begin
          if (!full_q) begin
            // Empty buffer: stall with the clock low; an accepted word goes straight to phase A.
            scan_clk_q <= 1'b0;
            if (cfg_valid_i) begin
              buf_q  <= cfg_data_i;
              idx_q  <= '0;
              full_q <= 1'b1;
              if (state_q == StConn) begin
                conn_in_q <= cfg_data_i[0];
              end else begin
                clb_in_q <= cfg_data_i[0];
              end
            end
          end else if (!scan_clk_q) begin
            scan_clk_q <= 1'b1;
          end else begin
            // End of phase B: the bit is consumed.
            scan_clk_q <= 1'b0;
            if (last_bit && (state_q == StClb)) begin
              // Trailing bits of the final word are dropped.
              state_q <= StFlush;
              full_q  <= 1'b0;
            end else begin
              if (last_bit) begin
                state_q   <= StClb;
                bit_cnt_q <= '0;
                conn_en_q <= 1'b0;
                conn_in_q <= 1'b0;
                clb_en_q  <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
              if (idx_q == IdxLast) begin
                full_q <= 1'b0;
              end else begin
                idx_q <= idx_nxt;
                if ((state_q == StConn) && !last_bit) begin
                  conn_in_q <= buf_q[idx_nxt];
                end else begin
                  clb_in_q <= buf_q[idx_nxt];
                end
              end
            end
          end
        end
        StFlush: begin
          // Data and enables were held for this cycle; now shut the chains off.
          state_q    <= StIdle;
          scan_clk_q <= 1'b0;
          conn_en_q  <= 1'b0;
          conn_in_q  <= 1'b0;
          clb_en_q   <= 1'b0;
          clb_in_q   <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: a small instance (5/3/4) driven by a cycle table and directed
// sequences, plus a default-size instance loaded with a random 40-word stream.
module tb_fpga_cfg_loader;

  logic clk;
  logic rst;

  // Small instance: CONN=5, CLB=3, WORD=4.
  logic       s_start, s_valid, s_ready, s_scan_clk;
  logic [3:0] s_data;
  logic       s_conn_in, s_conn_en, s_clb_in, s_clb_en, s_busy, s_done;

  // Default-size instance: CONN=256, CLB=64, WORD=8.
  logic       b_start, b_valid, b_ready, b_scan_clk;
  logic [7:0] b_data;
  logic       b_conn_in, b_conn_en, b_clb_in, b_clb_en, b_busy, b_done;

  int n_vec;
  int n_bad;

  fpga_cfg_loader #(
    .CONN_CHAIN_LEN(5),
    .CLB_CHAIN_LEN (3),
    .WORD_WIDTH    (4)
  ) u_small (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_start_i   (s_start),
    .cfg_data_i    (s_data),
    .cfg_valid_i   (s_valid),
    .cfg_ready_o   (s_ready),
    .scan_clk_o    (s_scan_clk),
    .conn_scan_in_o(s_conn_in),
    .conn_scan_en_o(s_conn_en),
    .clb_scan_in_o (s_clb_in),
    .clb_scan_en_o (s_clb_en),
    .busy_o        (s_busy),
    .done_o        (s_done)
  );

  fpga_cfg_loader u_big (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_start_i   (b_start),
    .cfg_data_i    (b_data),
    .cfg_valid_i   (b_valid),
    .cfg_ready_o   (b_ready),
    .scan_clk_o    (b_scan_clk),
    .conn_scan_in_o(b_conn_in),
    .conn_scan_en_o(b_conn_en),
    .clb_scan_in_o (b_clb_in),
    .clb_scan_en_o (b_clb_en),
    .busy_o        (b_busy),
    .done_o        (b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow chains: record every bit captured on a scan_clk rise (fpga_top model).
  int           s_rises, s_conn_n, s_clb_n;
  logic [255:0] s_conn_arr, s_clb_arr;
  initial begin
    s_rises = 0; s_conn_n = 0; s_clb_n = 0; s_conn_arr = '0; s_clb_arr = '0;
  end
  always @(posedge s_scan_clk) begin
    s_rises++;
    if (s_conn_en && s_conn_n < 256) begin s_conn_arr[s_conn_n] = s_conn_in; s_conn_n++; end
    if (s_clb_en && s_clb_n < 256) begin s_clb_arr[s_clb_n] = s_clb_in; s_clb_n++; end
  end

  int           b_rises, b_conn_n, b_clb_n, b_busy_cyc;
  logic [255:0] b_conn_arr;
  logic [63:0]  b_clb_arr;
  initial begin
    b_rises = 0; b_conn_n = 0; b_clb_n = 0; b_busy_cyc = 0; b_conn_arr = '0; b_clb_arr = '0;
  end
  always @(posedge b_scan_clk) begin
    b_rises++;
    if (b_conn_en && b_conn_n < 256) begin b_conn_arr[b_conn_n] = b_conn_in; b_conn_n++; end
    if (b_clb_en && b_clb_n < 64) begin b_clb_arr[b_clb_n] = b_clb_in; b_clb_n++; end
  end
  always @(posedge clk) if (b_busy) b_busy_cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Present one word to the small instance; called at a negedge, returns at a negedge.
  task automatic s_send(input logic [3:0] w);
    bit ok;
    ok      = 1'b0;
    s_data  = w;
    s_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (s_ready) ok = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    if (!ok) chk("word accept timeout", 32'(ok), 32'd1);
  endtask

  task automatic s_wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (s_done) ok = 1'b1;
      else @(negedge clk);
    end
    chk("done reached", 32'(ok), 32'd1);
  endtask

  // Full two-word load with optional back-pressure stall and an ignored mid-load start.
  task automatic run_load(input string tag, input logic [3:0] w0, input logic [3:0] w1,
                          input int stall_cyc, input bit mid_start);
    int         conn_base, clb_base;
    logic [7:0] stream;
    logic [4:0] got_conn;
    logic [2:0] got_clb;
    bit         ok;
    stream    = {w1, w0};
    conn_base = s_conn_n;
    clb_base  = s_clb_n;
    s_start   = 1'b1;
    @(negedge clk);
    s_start   = 1'b0;
    chk({tag, " start busy/done"}, {30'd0, s_busy, s_done}, 32'b10);
    s_send(w0);
    if (stall_cyc > 0) begin
      ok = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
        if (s_ready) ok = 1'b1;
        else @(negedge clk);
      end
      chk({tag, " drain"}, 32'(ok), 32'd1);
      for (int i = 0; i < stall_cyc; i++) begin
        chk({tag, " stall ready/clk/en"}, {29'd0, s_ready, s_scan_clk, s_conn_en}, 32'b101);
        chk({tag, " stall bit count"}, 32'(s_conn_n - conn_base), 32'd4);
        @(negedge clk);
      end
    end
    if (mid_start) begin
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      chk({tag, " mid start ignored"}, {30'd0, s_busy, s_conn_en}, 32'b11);
    end
    s_send(w1);
    s_wait_done();
    for (int i = 0; i < 5; i++) got_conn[i] = s_conn_arr[conn_base + i];
    for (int i = 0; i < 3; i++) got_clb[i] = s_clb_arr[clb_base + i];
    chk({tag, " conn count"}, 32'(s_conn_n - conn_base), 32'd5);
    chk({tag, " clb count"}, 32'(s_clb_n - clb_base), 32'd3);
    chk({tag, " conn bits"}, 32'(got_conn), 32'(stream[4:0]));
    chk({tag, " clb bits"}, 32'(got_clb), 32'(stream[7:5]));
    chk({tag, " final outputs"},
        {25'd0, s_ready, s_scan_clk, s_conn_en, s_clb_en, s_conn_in, s_clb_in, s_busy},
        32'd0);
  endtask

  // Expected outputs packed as {ready, scan_clk, conn_in, conn_en, clb_in, clb_en, busy, done}.
  typedef struct packed {
    logic       start;
    logic       valid;
    logic [3:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t tv[20];

  initial begin
    int         conn_base, clb_base, r0, wrong;
    logic [4:0] got_conn;
    logic [2:0] got_clb;
    logic [7:0] b_words[40];
    logic [7:0] got;
    logic [319:0] stream;
    bit         ok;

    n_vec = 0; n_bad = 0;
    rst = 1'b1;
    s_start = 1'b0; s_valid = 1'b0; s_data = '0;
    b_start = 1'b0; b_valid = 1'b0; b_data = '0;

    // Straddling load, valid held high: 1011 then 0110.
    tv[0]  = '{1'b1, 1'b0, 4'b0000, 8'b1001_0010};
    tv[1]  = '{1'b0, 1'b1, 4'b1011, 8'b0011_0010};
    tv[2]  = '{1'b0, 1'b1, 4'b0110, 8'b0111_0010};
    tv[3]  = '{1'b0, 1'b1, 4'b0110, 8'b0011_0010};
    tv[4]  = '{1'b0, 1'b1, 4'b0110, 8'b0111_0010};
    tv[5]  = '{1'b0, 1'b1, 4'b0110, 8'b0001_0010};
    tv[6]  = '{1'b0, 1'b1, 4'b0110, 8'b0101_0010};
    tv[7]  = '{1'b0, 1'b1, 4'b0110, 8'b0011_0010};
    tv[8]  = '{1'b0, 1'b1, 4'b0110, 8'b0111_0010};
    tv[9]  = '{1'b0, 1'b1, 4'b0110, 8'b1011_0010};
    tv[10] = '{1'b0, 1'b1, 4'b0110, 8'b0001_0010};
    tv[11] = '{1'b0, 1'b1, 4'b0110, 8'b0101_0010};
    tv[12] = '{1'b0, 1'b1, 4'b0110, 8'b0000_1110};
    tv[13] = '{1'b0, 1'b1, 4'b0110, 8'b0100_1110};
    tv[14] = '{1'b0, 1'b1, 4'b0110, 8'b0000_1110};
    tv[15] = '{1'b0, 1'b1, 4'b0110, 8'b0100_1110};
    tv[16] = '{1'b0, 1'b1, 4'b0110, 8'b0000_0110};
    tv[17] = '{1'b0, 1'b1, 4'b0110, 8'b0100_0110};
    tv[18] = '{1'b0, 1'b1, 4'b0110, 8'b0000_0110};
    tv[19] = '{1'b0, 1'b0, 4'b0000, 8'b0000_0001};

    repeat (3) @(negedge clk);
    chk("reset small outputs",
        {24'd0, s_ready, s_scan_clk, s_conn_in, s_conn_en, s_clb_in, s_clb_en, s_busy, s_done},
        32'd0);
    chk("reset big outputs",
        {24'd0, b_ready, b_scan_clk, b_conn_in, b_conn_en, b_clb_in, b_clb_en, b_busy, b_done},
        32'd0);
    rst = 1'b0;
    @(negedge clk);

    conn_base = s_conn_n;
    clb_base  = s_clb_n;
    for (int i = 0; i < 20; i++) begin
      s_start = tv[i].start;
      s_valid = tv[i].valid;
      s_data  = tv[i].data;
      @(posedge clk);
      #1;
      got = {s_ready, s_scan_clk, s_conn_in, s_conn_en, s_clb_in, s_clb_en, s_busy, s_done};
      if (got !== tv[i].exp) $display("FAIL table vector %0d: got %b expected %b", i, got,
                                      tv[i].exp);
      n_vec++;
      if (got !== tv[i].exp) n_bad++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) got_conn[i] = s_conn_arr[conn_base + i];
    for (int i = 0; i < 3; i++) got_clb[i] = s_clb_arr[clb_base + i];
    chk("table conn bits", 32'(got_conn), 32'b01011);
    chk("table clb bits", 32'(got_clb), 32'b011);
    chk("table scan_clk rises", 32'(s_rises), 32'd8);

    // Reload from DONE: start clears done, second load overwrites the chains.
    run_load("reload", 4'b0101, 4'b1100, 0, 1'b0);

    // cfg_valid while idle is ignored and consumes nothing.
    s_valid = 1'b1;
    s_data  = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle valid ignored", {30'd0, s_ready, s_busy}, 32'd0);
    end
    s_valid = 1'b0;

    run_load("stall", 4'b1011, 4'b0110, 6, 1'b0);
    run_load("midstart", 4'b0011, 4'b1110, 0, 1'b1);

    // Reset mid-word after two bits have been shifted.
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    r0 = s_rises;
    s_data  = 4'b1011;
    s_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (s_rises - r0 == 2) ok = 1'b1;
      else @(negedge clk);
    end
    chk("two bits before reset", 32'(ok), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid-load reset outputs",
        {26'd0, s_scan_clk, s_conn_en, s_clb_en, s_busy, s_ready, s_done}, 32'd0);
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    r0 = s_rises;
    repeat (10) @(negedge clk);
    chk("no scan_clk after reset", 32'(s_rises - r0), 32'd0);
    run_load("restart", 4'b1001, 4'b0111, 0, 1'b0);

    // Default-size instance, random 40-word stream.
    for (int i = 0; i < 40; i++) begin
      b_words[i] = 8'($urandom);
      stream[i*8 +: 8] = b_words[i];
    end
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      b_data  = b_words[i];
      b_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
        if (b_ready) ok = 1'b1;
        @(negedge clk);
      end
      b_valid = 1'b0;
      if (!ok) chk("big word accept timeout", 32'(ok), 32'd1);
    end
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (b_done) ok = 1'b1;
      else @(negedge clk);
    end
    chk("big done", 32'(ok), 32'd1);
    chk("big scan_clk rises", 32'(b_rises), 32'd320);
    chk("big conn count", 32'(b_conn_n), 32'd256);
    chk("big clb count", 32'(b_clb_n), 32'd64);
    wrong = 0;
    for (int k = 0; k < 256; k++) if (b_conn_arr[k] !== stream[k]) wrong++;
    for (int k = 0; k < 64; k++) if (b_clb_arr[k] !== stream[256 + k]) wrong++;
    chk("big chain bit errors", 32'(wrong), 32'd0);
    chk("big busy >= 640 cycles", 32'(b_busy_cyc >= 640), 32'd1);
    chk("big idle after done", {30'd0, b_busy, b_ready}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
